glb_iact_rd_sched: RTL

Read scheduler and port arbiter for the input-activation global buffer (iact GLB). It shares the GLB single read port among `NUM_REQ` PE-cluster requesters using round-robin burst arbitration. For each granted burst it generates sequential read addresses and returns data with a valid strobe aligned to the GLB's one-cycle registered read latency. The loader's write stream passes through to the GLB write port. Optionally, the scheduler stalls reads that collide with a same-cycle write.

---
 rtl/glb_iact_rd_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/glb_iact_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : glb_iact_rd_sched
// Description : Round-robin burst read scheduler for the iact GLB single read
//               port, with loader write pass-through. Optional read-after-write
//               collision stall enabled by defining GLB_IACT_RAW_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_iact_rd_sched #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int LEN_BITWIDTH  = 11,
    parameter int NUM_REQ       = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               rd_req,
    input  logic [NUM_REQ*ADDR_BITWIDTH-1:0] rd_base,
    input  logic [NUM_REQ*LEN_BITWIDTH-1:0]  rd_len,
    output logic [NUM_REQ-1:0]               rd_grant,
    output logic [DATA_BITWIDTH-1:0]         rd_data,
    output logic                             rd_valid,
    output logic [NUM_REQ-1:0]               rd_done,
    output logic                             busy,
    input  logic                             ld_write_en,
    input  logic [ADDR_BITWIDTH-1:0]         ld_w_addr,
    input  logic [DATA_BITWIDTH-1:0]         ld_w_data,
    output logic                             glb_read_req,
    output logic [ADDR_BITWIDTH-1:0]         glb_r_addr,
    input  logic [DATA_BITWIDTH-1:0]         glb_r_data,
    output logic                             glb_write_en,
    output logic [ADDR_BITWIDTH-1:0]         glb_w_addr,
    output logic [DATA_BITWIDTH-1:0]         glb_w_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         gnt_idx;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         hi_idx;
    logic [IDX_W-1:0]         lo_idx;
    logic                     hi_found;
    logic                     win_found;
    logic [NUM_REQ-1:0]       win_onehot;
    logic [ADDR_BITWIDTH-1:0] sel_base;
    logic [LEN_BITWIDTH-1:0]  sel_len;
    logic [ADDR_BITWIDTH-1:0] base;
    logic [LEN_BITWIDTH-1:0]  len;
    logic [LEN_BITWIDTH-1:0]  cnt;
    logic [DATA_BITWIDTH-1:0] data_hold;
    logic                     stall;
    logic                     issue;
    logic                     last_issue;

    // Lowest requester at or above the pointer wins; otherwise lowest overall.
    always_comb begin
        hi_found  = 1'b0;
        win_found = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rd_req[i]) begin
                win_found = 1'b1;
                lo_idx    = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_base   = '0;
        sel_len    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_base      = rd_base[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
                sel_len       = rd_len[i*LEN_BITWIDTH +: LEN_BITWIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign glb_r_addr = base + ADDR_BITWIDTH'(cnt);

`ifdef GLB_IACT_RAW_STALL_EN
    // Defer the read one cycle so it sees the word being written now.
    assign stall = (state == S_BURST) && ld_write_en && (ld_w_addr == glb_r_addr);
`else
    assign stall = 1'b0;
`endif

    assign issue      = (state == S_BURST) && (len != '0) && !stall;
    assign last_issue = issue && (cnt == len - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        glb_read_req = 1'b0;
        rd_done      = '0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (win_found) state_nxt = S_BURST;
            end
            S_BURST: begin
                glb_read_req = issue;
                if ((len == '0) || last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                rd_done   = rd_grant;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_grant  <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            base      <= '0;
            len       <= '0;
            cnt       <= '0;
            rd_valid  <= 1'b0;
            data_hold <= '0;
        end else begin
            rd_valid <= glb_read_req;
            if (rd_valid) data_hold <= glb_r_data;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        rd_grant <= win_onehot;
                        gnt_idx  <= win_idx;
                        base     <= sel_base;
                        len      <= sel_len;
                        cnt      <= '0;
                    end
                end
                S_BURST: begin
                    if (issue) cnt <= cnt + 1'b1;
                end
                S_DRAIN: begin
                    rd_grant <= '0;
                    rr_ptr   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The GLB drives an idle word when not read; only forward issued reads.
    assign rd_data = rd_valid ? glb_r_data : data_hold;

    assign glb_write_en = ld_write_en;
    assign glb_w_addr   = ld_w_addr;
    assign glb_w_data   = ld_w_data;

endmodule
`default_nettype wire
